// File: rtl/loop_seq_ctrl_pkg.sv
// Shared definitions for the loop sequencer: state encoding and parameter defaults.
// Defining LOOP_SEQ_WRAP_EN lets runs with last_idx < first_idx wrap through the top index.
package loop_seq_ctrl_pkg;

    localparam int IDX_W_DEF   = 3;
    localparam int TIMEOUT_DEF = 15;

`ifdef LOOP_SEQ_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_STEP  = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

endpackage

// File: rtl/loop_seq_ctrl_if.sv
// Counter and element-processor signals seen by the loop sequencer.
// master = the sequencer, slave = counter plus element processor.
interface loop_seq_ctrl_if #(
    parameter int IDX_W = 3
) ();

    logic             cnt_ld;
    logic             cnt_inc;
    logic [IDX_W-1:0] cnt_data;
    logic [IDX_W-1:0] cnt_out;
    logic             elem_req;
    logic             elem_ack;

    modport master (
        output cnt_ld,
        output cnt_inc,
        output cnt_data,
        output elem_req,
        input  cnt_out,
        input  elem_ack
    );

    modport slave (
        input  cnt_ld,
        input  cnt_inc,
        input  cnt_data,
        input  elem_req,
        output cnt_out,
        output elem_ack
    );

endinterface

// File: rtl/loop_seq_timer.sv
// Per-element acknowledge wait counter; hit_o flags the waiting cycle that
// would bring the count to TIMEOUT (never asserted when TIMEOUT is 0).
module loop_seq_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TW-1:0] LIM_V = TW'(LIM);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

    assign hit_o = (TIMEOUT != 0) && en_i && (cnt_q == LIM_V);

endmodule

// File: rtl/loop_seq_ctrl.sv
// Loop sequencer: steps an external loadable counter over [first_idx..last_idx] with one
// req/ack handshake per index. LOOP_SEQ_WRAP_EN allows wrapping ranges (last < first).
module loop_seq_ctrl
    import loop_seq_ctrl_pkg::*;
#(
    parameter int IDX_W   = IDX_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W-1:0] first_idx,
    input  logic [IDX_W-1:0] last_idx,
    output logic             busy,
    output logic             done,
    output logic             err,
    loop_seq_ctrl_if.master  bus
);

    state_e           state_q;
    logic [IDX_W-1:0] first_q;
    logic [IDX_W-1:0] last_q;
    logic             cnt_ld_q;
    logic             cnt_inc_q;
    logic             elem_req_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             tmr_hit;
    logic             tmr_en;
    logic             tmr_clr;

    function automatic logic range_ok(input logic [IDX_W-1:0] f, input logic [IDX_W-1:0] l);
        return WRAP_EN || (l >= f);
    endfunction

    assign tmr_en  = (state_q == ST_ISSUE) && !bus.elem_ack;
    assign tmr_clr = (state_q != ST_ISSUE);

    loop_seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .hit_o (tmr_hit)
    );

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            first_q    <= '0;
            last_q     <= '0;
            cnt_ld_q   <= 1'b0;
            cnt_inc_q  <= 1'b0;
            elem_req_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_ld_q  <= 1'b0;
            cnt_inc_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    elem_req_q <= 1'b0;
                    busy_q     <= 1'b0;
                    if (start) begin
                        first_q <= first_idx;
                        last_q  <= last_idx;
                        if (range_ok(first_idx, last_idx)) begin
                            state_q  <= ST_LOAD;
                            cnt_ld_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    state_q    <= ST_ISSUE;
                    elem_req_q <= 1'b1;
                end
                ST_ISSUE: begin
                    // An ack on the limit cycle still counts as a completed handshake.
                    if (bus.elem_ack) begin
                        elem_req_q <= 1'b0;
                        if (bus.cnt_out == last_q) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= ST_STEP;
                            cnt_inc_q <= 1'b1;
                        end
                    end else if (tmr_hit) begin
                        state_q    <= ST_IDLE;
                        elem_req_q <= 1'b0;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                    end
                end
                ST_STEP: begin
                    state_q    <= ST_ISSUE;
                    elem_req_q <= 1'b1;
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    elem_req_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cnt_ld   = cnt_ld_q;
    assign bus.cnt_inc  = cnt_inc_q;
    assign bus.cnt_data = first_q;
    assign bus.elem_req = elem_req_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule
